// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS controller: opcode constants,
// FSM state encodings, datapath select encodings and the packed control word
// produced by the state decoder. The datapath and the bench reuse these.
//
// Configuration macro: BNE_EN -- when defined, opcode 6'b000101 (bne) is a
// legal branch; otherwise it decodes as illegal.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  // Controller states; 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  // PC source select
  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,  // ALU result (PC+4)
    PC_SRC_ALUOUT = 2'b01,  // ALUOut (branch target)
    PC_SRC_JUMP   = 2'b10   // {PC[31:28], IR[25:0], 2'b00}
  } pc_src_e;

  // ALU operand B select
  typedef enum logic [1:0] {
    SRC_B_REG     = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH2 = 2'b11
  } alu_src_b_e;

  // ALU operation class
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  // Instruction class derived from the opcode
  typedef enum logic [2:0] {
    OPC_MEM,
    OPC_RTYPE,
    OPC_BRANCH,
    OPC_JUMP,
    OPC_ADDI,
    OPC_ILLEGAL
  } op_class_e;

  // Full control word driven to the datapath
  typedef struct packed {
    logic       pc_en;
    pc_src_e    pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic op_class_e decode_op(input logic [5:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_LW, OP_SW: cls = OPC_MEM;
      OP_RTYPE:     cls = OPC_RTYPE;
      OP_BEQ:       cls = OPC_BRANCH;
`ifdef BNE_EN
      OP_BNE:       cls = OPC_BRANCH;
`endif
      OP_J:         cls = OPC_JUMP;
      OP_ADDI:      cls = OPC_ADDI;
      default:      cls = OPC_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Combinational state-to-control-word decoder for the multi-cycle controller.
// Outputs are Moore-decoded from the state except pc_en/ir_wr in FETCH (gated
// by mem_ready), pc_en in BRANCH (gated by zero) and illegal_op in DECODE.
// The whole word is forced to zero while the controller is held in reset.
//
// Ports:
//   state_i      current FSM state
//   opcode_i     IR[31:26]
//   zero_i       ALU zero flag
//   mem_ready_i  memory access complete this cycle
//   active_i     1 when reset is deasserted
//   ctrl_o       control word to the datapath
//
// Configuration macro: BNE_EN -- BRANCH takes pc_en = ~zero for bne.
// -----------------------------------------------------------------------------
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  input  logic        active_i,
  output ctrl_t       ctrl_o
);

  ctrl_t ctrl;

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    ctrl = '0;
    case (state_i)
      S_FETCH: begin
        ctrl.iord      = 1'b0;
        ctrl.mem_rd    = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        // IR and PC load only on the cycle the instruction word arrives.
        ctrl.ir_wr     = mem_ready_i;
        ctrl.pc_en     = mem_ready_i;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRC_B_IMM_SH2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = (decode_op(opcode_i) == OPC_ILLEGAL);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_rd = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_wr = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
`ifdef BNE_EN
        ctrl.pc_en     = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
`else
        ctrl.pc_en     = zero_i;
`endif
      end
      S_JUMP: begin
        ctrl.pc_src = PC_SRC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: ctrl = '0;  // unused encodings drive nothing
    endcase

    // Reset gates the word asynchronously so no request leaks out of FETCH
    // (or an aborted MEMWR) while reset is low.
    if (!active_i) ctrl = '0;
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Main controller of the multi-cycle MIPS core. Holds the state register and
// next-state logic; the control word comes from mc_ctrl_decode. Every memory
// access (FETCH, MEMRD, MEMWR) waits on mem_ready.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   opcode     IR[31:26], sampled in DECODE, MEMADR and BRANCH
//   zero       ALU zero flag, valid in BRANCH
//   mem_ready  memory access complete this cycle
//   pc_en, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
//   alu_src_a, alu_src_b, alu_op   datapath controls
//   illegal_op one-cycle pulse in DECODE on an unknown opcode
//   state      current state encoding (debug)
//
// Configuration macro: BNE_EN -- bne (6'b000101) is executed as a branch.
// -----------------------------------------------------------------------------
module mc_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_wr,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (decode_op(opcode))
          OPC_MEM:    state_d = S_MEMADR;
          OPC_RTYPE:  state_d = S_EXEC;
          OPC_BRANCH: state_d = S_BRANCH;
          OPC_JUMP:   state_d = S_JUMP;
          OPC_ADDI:   state_d = S_ADDIEX;
          default:    state_d = S_FETCH;  // illegal: flagged, then refetch
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .active_i    (reset),
    .ctrl_o      (ctrl)
  );

  assign pc_en      = ctrl.pc_en;
  assign pc_src     = ctrl.pc_src;
  assign iord       = ctrl.iord;
  assign mem_rd     = ctrl.mem_rd;
  assign mem_wr     = ctrl.mem_wr;
  assign ir_wr      = ctrl.ir_wr;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_wr     = ctrl.reg_wr;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal_op = ctrl.illegal_op;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Self-checking bench for mc_control_fsm. Each scenario task lists the state
// sequence the controller must walk; per cycle the expected output vector is
// pushed to a scoreboard queue and popped for comparison at the falling edge.
// Honours BNE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;
  import mips_ctrl_pkg::*;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, EX = 4'd6, AWB = 4'd7, BR = 4'd8,
                         JP = 4'd9, AEX = 4'd10, AWB2 = 4'd11;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } obs_t;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr;
  logic       alu_src_a, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int ir_cnt, rw_cnt, cyc_cnt;
  obs_t exp_q[$];

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o = '{state, pc_en, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_dst,
          mem_to_reg, reg_wr, alu_src_a, alu_src_b, alu_op, illegal_op};
    return o;
  endfunction

  function automatic logic known_op(input logic [5:0] opc);
    logic k;
    k = (opc == 6'b000000) || (opc == 6'b100011) || (opc == 6'b101011) ||
        (opc == 6'b000100) || (opc == 6'b001000) || (opc == 6'b000010);
`ifdef BNE_EN
    k = k || (opc == 6'b000101);
`endif
    return k;
  endfunction

  // Expected outputs for one cycle, written from the controller's output table.
  function automatic obs_t exp_out(input logic [3:0] st, input logic [5:0] opc,
                                   input logic z, input logic rdy);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      F:    begin e.mem_rd = 1; e.alu_src_b = 2'b01; e.ir_wr = rdy; e.pc_en = rdy; end
      D:    begin e.alu_src_b = 2'b11; e.illegal_op = !known_op(opc); end
      MA:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      MR:   begin e.iord = 1; e.mem_rd = 1; end
      MWB:  begin e.reg_wr = 1; e.mem_to_reg = 1; end
      MW:   begin e.iord = 1; e.mem_wr = 1; end
      EX:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      AWB:  begin e.reg_wr = 1; e.reg_dst = 1; end
      BR: begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
`ifdef BNE_EN
        e.pc_en = (opc == 6'b000101) ? ~z : z;
`else
        e.pc_en = z;
`endif
      end
      JP:   begin e.pc_src = 2'b10; e.pc_en = 1; end
      AEX:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      AWB2: begin e.reg_wr = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // One clock cycle: push expectation, compare at negedge, advance to posedge+1.
  task automatic cycle(input string name, input logic [3:0] st);
    obs_t e, o;
    exp_q.push_back(exp_out(st, opcode, zero, mem_ready));
    @(negedge clk);
    o = observe();
    e = exp_q.pop_front();
    n_checks++;
    if (o !== e)
      $display("FAIL %s st%0d: got %h expected %h", name, st, o, e);
    else
      n_pass++;
    if (o.ir_wr)  ir_cnt++;
    if (o.reg_wr) rw_cnt++;
    cyc_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %0d expected %0d", name, got, want);
    else n_pass++;
  endtask

  task automatic check_zero_outputs(input string name);
    obs_t o;
    o = observe();
    n_checks++;
    if (o !== obs_t'('0)) $display("FAIL %s: got %h expected 0", name, o);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = OP_RTYPE;
    @(negedge clk);
    check_zero_outputs("reset_idle");
    mem_ready = 1'b1; opcode = OP_J;
    @(negedge clk);
    check_zero_outputs("reset_ready");
    @(posedge clk); #1;
    reset = 1'b1;
    cycle("j_fetch", F);
    cycle("j_decode", D);
    cycle("j_jump", JP);
  endtask

  task automatic test_lw_wait;
    opcode = OP_LW; ir_cnt = 0; rw_cnt = 0; cyc_cnt = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("lw_fetch_wait", F);
    mem_ready = 1'b1;
    cycle("lw_fetch", F);
    cycle("lw_decode", D);
    mem_ready = 1'b0;  // ignored in MEMADR
    cycle("lw_memadr", MA);
    for (int i = 0; i < 2; i++) cycle("lw_memrd_wait", MR);
    mem_ready = 1'b1;
    cycle("lw_memrd", MR);
    cycle("lw_memwb", MWB);
    check_int("lw_ir_wr_pulses", ir_cnt, 1);
    check_int("lw_reg_wr_cycles", rw_cnt, 1);
    check_int("lw_total_cycles", cyc_cnt, 10);
  endtask

  task automatic test_beq;
    opcode = OP_BEQ; mem_ready = 1'b1; zero = 1'b1;
    cycle("beq_t_fetch", F);
    mem_ready = 1'b0;  // ignored in DECODE/BRANCH
    cycle("beq_t_decode", D);
    cycle("beq_t_branch", BR);
    mem_ready = 1'b1; zero = 1'b0;
    cycle("beq_n_fetch", F);
    cycle("beq_n_decode", D);
    cycle("beq_n_branch", BR);
  endtask

  task automatic test_illegal;
    logic [5:0] bne_op;
    bne_op = 6'b000101;
    opcode = 6'b111111; mem_ready = 1'b1; zero = 1'b0;
    cycle("ill_fetch", F);
    cycle("ill_decode", D);
    opcode = bne_op;
    cycle("bne_fetch", F);
    cycle("bne_decode", D);
`ifdef BNE_EN
    cycle("bne_branch", BR);
`endif
  endtask

  task automatic test_back_to_back;
    mem_ready = 1'b1; ir_cnt = 0; rw_cnt = 0; cyc_cnt = 0;
    opcode = OP_RTYPE;
    cycle("r_fetch", F);
    cycle("r_decode", D);
    cycle("r_exec", EX);
    cycle("r_aluwb", AWB);
    opcode = OP_ADDI;
    cycle("addi_fetch", F);
    cycle("addi_decode", D);
    cycle("addi_exec", AEX);
    cycle("addi_wb", AWB2);
    check_int("b2b_total_cycles", cyc_cnt, 8);
  endtask

  task automatic test_sw_reset;
    opcode = OP_SW; mem_ready = 1'b1;
    cycle("sw_fetch", F);
    cycle("sw_decode", D);
    cycle("sw_memadr", MA);
    mem_ready = 1'b0;
    cycle("sw_memwr_wait", MW);
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("sw_reset_abort");
    @(posedge clk); #1;
    check_zero_outputs("sw_reset_held");
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_J;
    cycle("restart_fetch", F);
    cycle("restart_decode", D);
    cycle("restart_jump", JP);
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_sw_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle main controller that sequences the program counter, instruction register, register file, ALU and unified memory of the multi-cycle MIPS core. It decodes the 6-bit opcode latched in IR and steps through fetch/decode/execute/memory/writeback states. It drives the PC update enable and source select, replacing the single-cycle jump/pcsrc pair. It waits on a memory ready handshake for every memory access.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch equal
OP_ADDI, 6'b001000, add immediate
OP_J, 6'b000010, jump

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]
zero  in  1  ALU zero flag, valid in BRANCH
mem_ready  in  1  memory access complete this cycle
pc_en  out  1  PC register load enable
pc_src  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target {PC[31:28],IR[25:0],2'b00}
iord  out  1  0 address=PC, 1 address=ALUOut
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
ir_wr  out  1  IR load enable
reg_dst  out  1  1 rd, 0 rt
mem_to_reg  out  1  1 MDR, 0 ALUOut
reg_wr  out  1  register file write enable
alu_src_a  out  1  0 PC, 1 reg A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 use funct
illegal_op  out  1  one-cycle pulse on unknown opcode
state  out  4  current state encoding (debug)

Behaviour:
- State register updates on posedge clk. reset low clears it to FETCH(0) immediately. While reset is low, all enables and requests (pc_en, ir_wr, mem_rd, mem_wr, reg_wr, illegal_op) are 0. All other outputs are 0.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- FETCH: iord=0, mem_rd=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_wr=pc_en=mem_ready. Stay until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX. Any other opcode: illegal_op=1 for this cycle, then FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW->MEMRD, SW->MEMWR.
- MEMRD: iord=1, mem_rd=1. Hold until mem_ready, then MEMWB. MEMWB: reg_wr=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEMWR: iord=1, mem_wr=1. Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB. ALUWB: reg_wr=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, then FETCH.
- JUMP: pc_src=10, pc_en=1, then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDIWB. ADDIWB: reg_wr=1, reg_dst=0, mem_to_reg=0, then FETCH.
- Outputs are Moore-decoded from state. Exceptions: pc_en/ir_wr in FETCH and pc_en in BRANCH are gated by the inputs as stated. Unlisted outputs are 0 in each state.
- Latency with mem_ready=1 throughout: LW 5 cycles, SW/R-type/ADDI 4, BEQ/J 3, illegal 2.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR. mem_rd and mem_wr are held stable while waiting. They are never both 1.
- opcode is sampled in DECODE, MEMADR and BRANCH only; IR is stable after FETCH.
- Unused encodings 12-15 return to FETCH on the next clock, with all outputs 0.
- Reset asserted mid-instruction aborts it. No write occurs in the reset cycle.

Optional Feature:
Macro BNE_EN. When defined, opcode 6'b000101 (bne) goes from DECODE to BRANCH. In BRANCH, pc_en = ~zero for bne and pc_en = zero for beq. When not defined, 000101 is illegal and raises illegal_op.

Decomposition:
- Shared package/header mips_ctrl_pkg: opcode constants, state encodings, pc_src, alu_src_b and alu_op encodings. These are reused by the datapath and the bench.
- One natural sub-module, mc_ctrl_decode: the combinational state-to-control-word decoder. The FSM top holds only the state register and next-state logic.

Test Plan:
- reset low at t=0, release with mem_ready=1 and opcode=OP_J -> state 0,1,9,0. pc_en=1 in FETCH and JUMP with pc_src=10 in JUMP.
- opcode=OP_LW, mem_ready held low 3 cycles in FETCH and 2 in MEMRD -> FETCH held 4 cycles. Exactly one ir_wr pulse, and reg_wr=1 only in MEMWB. Total 10 cycles.
- opcode=OP_BEQ with zero=1, then zero=0 -> pc_en=1 and pc_src=01 in BRANCH, then pc_en=0. Back to FETCH next cycle in both cases.
- opcode=6'b111111 -> illegal_op=1 for one cycle in DECODE, no reg_wr/mem_wr, FETCH next. With BNE_EN defined, opcode=000101 and zero=0 -> pc_en=1 in BRANCH.
- opcode=OP_SW, reset driven low during MEMWR -> state=0 immediately, mem_wr=0 in the same cycle. Fetch restarts after release.
- Back-to-back R-type and ADDI -> 4 cycles each. reg_dst=1 for R-type and 0 for ADDI in the writeback state. alu_op=10 in EXEC.
